// File: rtl/seg_pkg.sv
// Shared types and arithmetic helpers for the balance-loop front end.
// Pure definitions, no timing.
// No flow control; consumed by inertial_integrator and its sub-blocks.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Accel-Z to pitch scale factor, applied before a >>>13.
    localparam int ACC_SCALE   = 327;
    // Complementary-filter nudge per sample toward the accel pitch.
    localparam int FUSION_STEP = 1024;
    // Integrator width; pitch output is bits [26:11].
    localparam int INT_W       = 27;

    // Clamp a 17-bit signed difference into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x[16] != x[15]) begin
            return x[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return x[15:0];
    endfunction

    // Clamp a widened integrator sum into [-2^26, 2^26-1].
    function automatic logic signed [INT_W-1:0] sat27(input logic signed [INT_W+1:0] x);
        if ((x[INT_W+1:INT_W-1] != 3'b000) && (x[INT_W+1:INT_W-1] != 3'b111)) begin
            return x[INT_W+1] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        end
        return x[INT_W-1:0];
    endfunction

endpackage

// File: rtl/inertial_integrator_gyro_cal.sv
// Gyro offset calibration: averages 2^CAL_LOG raw rate samples into an offset.
// Offset/done register on the edge of the sample that completes the set.
// No backpressure; every vld_i is accepted, clr_i has priority over vld_i.
module gyro_cal #(
    parameter int CAL_LOG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        vld_i,
    input  logic [15:0] raw_i,
    output logic [15:0] offset_o,
    output logic        done_o,
    output logic        fin_o
);
    localparam int ACC_W = 16 + CAL_LOG;

    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [CAL_LOG-1:0] cnt_q, cnt_d;
    logic [15:0]        offset_q, offset_d;
    logic               done_q, done_d;

    // Running sum includes the current sample, so the final sample counts.
    assign acc_sum = acc_q + {{CAL_LOG{raw_i[15]}}, raw_i};
    assign fin_o   = vld_i && (cnt_q == '1);

    // Accumulate samples; the top 16 bits of the final sum are acc >>> CAL_LOG.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        done_d   = done_q;
        if (clr_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (vld_i) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (fin_o) begin
                offset_d = acc_sum[ACC_W-1 -: 16];
                done_d   = 1'b1;
            end
        end
    end

    // State registers; offset survives clr so only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            offset_q <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            done_q   <= done_d;
        end
    end

    assign offset_o = offset_q;
    assign done_o   = done_q;

endmodule

// File: rtl/inertial_integrator.sv
// Gyro/accel fusion front end: calibrates gyro offset, then integrates pitch.
// Latency 1: a vld in RUN updates ptch/ptch_rt and pulses vld_out next cycle.
// No backpressure; pwr_up low overrides vld and returns to IDLE.
module inertial_integrator
    import seg_pkg::*;
#(
    parameter int          fast_sim  = 0,
    parameter logic [15:0] AZ_OFFSET = 16'hFE80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic        vld,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld_out,
    output logic        cal_done
);
    localparam int CAL_LOG = (fast_sim != 0) ? 2 : 8;

    state_t state_q, state_d;

    logic        cal_clr, cal_vld, cal_fin, cal_done_w;
    logic [15:0] offset;
    logic        upd;

    logic signed [16:0]      diff;
    logic signed [15:0]      rate;
    logic [15:0]             az_comp;
    logic signed [25:0]      az_ext, prod, ptch_acc, ptch_ext;
    logic signed [INT_W+1:0] fusion, int_ext, rate_ext, sum;
    logic signed [INT_W-1:0] ptch_int_q, ptch_int_d;
    logic signed [15:0]      ptch_q, ptch_rt_q;
    logic                    vld_out_q;

    // Calibrator is cleared whenever balance is off or the FSM sits in IDLE.
    assign cal_clr = !pwr_up || (state_q == IDLE);
    assign cal_vld = pwr_up && vld && (state_q == CAL);

    gyro_cal #(.CAL_LOG(CAL_LOG)) u_gyro_cal (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cal_clr),
        .vld_i    (cal_vld),
        .raw_i    (ptch_rt_raw),
        .offset_o (offset),
        .done_o   (cal_done_w),
        .fin_o    (cal_fin)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and integrator update strobe; pwr_up low beats everything.
    always_comb begin
        state_d = state_q;
        upd     = 1'b0;
        if (!pwr_up) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CAL;
                CAL:     if (cal_fin) state_d = RUN;
                RUN:     upd = vld;
                default: state_d = IDLE;
            endcase
        end
    end

    // Rate correction, accel pitch estimate, fusion nudge and saturating integrate.
    always_comb begin
        diff     = $signed({ptch_rt_raw[15], ptch_rt_raw}) - $signed({offset[15], offset});
        rate     = sat16(diff);
        az_comp  = AZ - AZ_OFFSET;
        az_ext   = $signed({{10{az_comp[15]}}, az_comp});
        prod     = az_ext * $signed(26'(ACC_SCALE));
        ptch_acc = prod >>> 13;
        ptch_ext = $signed({{10{ptch_q[15]}}, ptch_q});
        fusion   = '0;
        if (ptch_acc > ptch_ext) begin
            fusion = 29'(FUSION_STEP);
        end else if (ptch_acc < ptch_ext) begin
            fusion = -29'(FUSION_STEP);
        end
        int_ext    = $signed({{2{ptch_int_q[INT_W-1]}}, ptch_int_q});
        rate_ext   = $signed({{(INT_W+2-16){rate[15]}}, rate});
        sum        = int_ext - rate_ext + fusion;
        ptch_int_d = sat27(sum);
    end

    // Output and integrator registers; cleared while idle or powering down.
    always_ff @(posedge clk) begin
        if (rst || cal_clr) begin
            ptch_int_q <= '0;
            ptch_q     <= '0;
            ptch_rt_q  <= '0;
            vld_out_q  <= 1'b0;
        end else if (upd) begin
            ptch_int_q <= ptch_int_d;
            ptch_q     <= ptch_int_d[INT_W-1 -: 16];
            ptch_rt_q  <= rate;
            vld_out_q  <= 1'b1;
        end else begin
            vld_out_q  <= 1'b0;
        end
    end

    assign ptch     = ptch_q;
    assign ptch_rt  = ptch_rt_q;
    assign vld_out  = vld_out_q;
    assign cal_done = cal_done_w;

endmodule

// File: tb/tb_inertial_integrator.sv
// Self-checking bench for inertial_integrator against an integer reference model.
// One step per clock: inputs driven at negedge, outputs checked 1 time unit after posedge.
// Directed scenarios followed by a randomized soak.
module tb_inertial_integrator;

    localparam logic [15:0] AZ_OFF = 16'hFE80;
    localparam int          CAL_N  = 256;

    logic        clk = 1'b0;
    logic        rst, pwr_up, vld;
    logic [15:0] ptch_rt_raw, AZ;
    logic [15:0] ptch, ptch_rt;
    logic        vld_out, cal_done;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state (plain integers)
    int m_state;   // 0 idle, 1 calibrating, 2 running
    int m_acc, m_cnt, m_off, m_pint, m_ptch, m_rate, m_vo, m_done;

    always #5 clk = ~clk;

    inertial_integrator #(.fast_sim(0), .AZ_OFFSET(AZ_OFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_up      (pwr_up),
        .vld         (vld),
        .ptch_rt_raw (ptch_rt_raw),
        .AZ          (AZ),
        .ptch        (ptch),
        .ptch_rt     (ptch_rt),
        .vld_out     (vld_out),
        .cal_done    (cal_done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floordiv(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit v,
                              input logic [15:0] raw, input logic [15:0] az);
        int rawi, azc, pacc, fus, s;
        logic [15:0] azw;
        rawi = $signed(raw);
        azw  = az - AZ_OFF;
        azc  = $signed(azw);
        m_vo = 0;
        if (r) begin
            m_state = 0; m_acc = 0; m_cnt = 0; m_off = 0;
            m_pint = 0; m_ptch = 0; m_rate = 0; m_done = 0;
        end else if (!p) begin
            m_state = 0; m_acc = 0; m_cnt = 0;
            m_pint = 0; m_ptch = 0; m_rate = 0; m_done = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_acc = 0; m_cnt = 0;
        end else if (m_state == 1) begin
            if (v) begin
                m_acc += rawi;
                m_cnt++;
                if (m_cnt == CAL_N) begin
                    m_off   = floordiv(m_acc, CAL_N);
                    m_done  = 1;
                    m_state = 2;
                end
            end
        end else begin
            if (v) begin
                m_rate = clamp(rawi - m_off, -32768, 32767);
                pacc   = floordiv(azc * 327, 8192);
                fus    = (pacc > m_ptch) ? 1024 : ((pacc < m_ptch) ? -1024 : 0);
                s      = clamp(m_pint - m_rate + fus, -(1 << 26), (1 << 26) - 1);
                m_pint = s;
                m_ptch = floordiv(s, 2048);
                m_vo   = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit p, input bit v,
                        input logic [15:0] raw, input logic [15:0] az);
        @(negedge clk);
        rst = r; pwr_up = p; vld = v; ptch_rt_raw = raw; AZ = az;
        @(posedge clk);
        model_step(r, p, v, raw, az);
        #1;
        check_val("ptch",     32'(ptch),     m_ptch & 32'hFFFF);
        check_val("ptch_rt",  32'(ptch_rt),  m_rate & 32'hFFFF);
        check_val("vld_out",  32'(vld_out),  32'(m_vo));
        check_val("cal_done", 32'(cal_done), 32'(m_done));
    endtask

    // Power-cycle, then feed a full calibration set with occasional idle gaps.
    task automatic calibrate(input logic [15:0] raw);
        step(0, 0, 0, 16'h0, AZ_OFF);
        step(0, 1, 0, 16'h0, AZ_OFF);
        for (int i = 0; i < CAL_N; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 1, 0, raw, AZ_OFF);
            step(0, 1, 1, raw, AZ_OFF);
            check_val("cal_novo", 32'(vld_out), 32'd0);
            check_val("cal_rise", 32'(cal_done), (i == CAL_N - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic signed [15:0] prev;
        rst = 1'b1; pwr_up = 1'b0; vld = 1'b0; ptch_rt_raw = '0; AZ = AZ_OFF;
        m_state = 0; m_acc = 0; m_cnt = 0; m_off = 0;
        m_pint = 0; m_ptch = 0; m_rate = 0; m_vo = 0; m_done = 0;

        // Reset state
        step(1, 0, 0, 16'h0, AZ_OFF);
        step(1, 1, 1, 16'h1234, AZ_OFF);
        check_val("rst_ptch", 32'(ptch), 32'd0);
        check_val("rst_rt",   32'(ptch_rt), 32'd0);
        check_val("rst_done", 32'(cal_done), 32'd0);

        // Calibration to offset 0x0050, then pure gyro integration
        calibrate(16'h0050);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 16'hF850, AZ_OFF);
            check_val("rt_f800", 32'(ptch_rt), 32'h0000F800);
            check_val("int_vo",  32'(vld_out), 32'd1);
        end
        check_val("int_ptch5", 32'(ptch), 32'd5);
        step(0, 1, 0, 16'hF850, AZ_OFF);
        check_val("novld_hold", 32'(ptch), 32'd5);
        check_val("novld_vo",   32'(vld_out), 32'd0);

        // pwr_up falls together with vld
        step(0, 0, 1, 16'hF850, AZ_OFF);
        check_val("drop_ptch", 32'(ptch), 32'd0);
        check_val("drop_rt",   32'(ptch_rt), 32'd0);
        check_val("drop_vo",   32'(vld_out), 32'd0);
        check_val("drop_done", 32'(cal_done), 32'd0);

        // Recalibrate, then accel-only convergence toward pitch 39
        calibrate(16'h0050);
        for (int i = 1; i <= 88; i++) begin
            step(0, 1, 1, 16'h0050, AZ_OFF + 16'd1000);
            if (i == 77) check_val("conv_77", 32'(ptch), 32'd38);
            if (i >= 78) check_val("conv_39", 32'(ptch), 32'd39);
        end

        // Rate saturation drives pitch to the positive rail without wrapping
        calibrate(16'h0050);
        prev = 16'sh0;
        for (int i = 0; i < 2300; i++) begin
            step(0, 1, 1, 16'h8000, AZ_OFF);
            check_val("sat_rt",   32'(ptch_rt), 32'h00008000);
            check_val("sat_mono", 32'($signed(ptch) >= prev), 32'd1);
            prev = $signed(ptch);
        end
        check_val("sat_rail", 32'(ptch), 32'h00007FFF);

        // Reset part-way through calibration restarts the sample count
        step(0, 0, 0, 16'h0, AZ_OFF);
        step(0, 1, 0, 16'h0, AZ_OFF);
        for (int i = 0; i < 100; i++) step(0, 1, 1, 16'h0030, AZ_OFF);
        step(1, 1, 1, 16'h0030, AZ_OFF);
        step(0, 1, 0, 16'h0030, AZ_OFF);
        for (int i = 0; i < CAL_N; i++) begin
            step(0, 1, 1, 16'h0030, AZ_OFF);
            check_val("rcal_done", 32'(cal_done), (i == CAL_N - 1) ? 32'd1 : 32'd0);
        end

        // Randomized soak against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 1499) == 0),
                 ($urandom_range(0, 599) != 0),
                 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
